// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized neuron array and its parameter loader.
package bnn_pkg;

   localparam int NEURONS               = 8;
   localparam int PARAM_BITS_PER_NEURON = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SHIFT,
      ST_VERIFY,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/bnn_param_loader_if.sv
// Byte-stream input and neuron-chain shift port of the parameter loader.
interface bnn_param_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       setup;
   logic       param_out;
   logic       param_return;

   // master: byte source plus neuron chain; slave: the loader
   modport master (
      output in_data, in_valid, param_return,
      input  in_ready, setup, param_out
   );

   modport slave (
      input  in_data, in_valid, param_return,
      output in_ready, setup, param_out
   );

endinterface

// File: rtl/bnn_param_buffer.sv
// Parameter image storage: byte-wide write port, bit-wide read port (MSB first per byte).
module bnn_param_buffer #(
   parameter  int CHAIN_BYTES = 12,
   localparam int BYTE_W      = $clog2(CHAIN_BYTES),
   localparam int BIT_W       = $clog2(CHAIN_BYTES * 8)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_idx,
   input  logic [7:0]        wr_data,
   input  logic [BIT_W-1:0]  rd_idx,
   output logic              rd_bit
);

   // No reset: every load overwrites the whole image before it is read.
   logic [7:0] mem [CHAIN_BYTES];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_bit = mem[rd_idx[BIT_W-1:3]][3'd7 - rd_idx[2:0]];

endmodule

// File: rtl/bnn_param_loader.sv
// Loads a byte-stream parameter image into the neuron chain, then re-shifts it
// once more while checking the chain tail against the image.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start; outputs quiet, ok/err_count held
//   ST_FILL   | accepting CHAIN_BYTES image bytes
//   ST_SHIFT  | setup=1, image bits 0..CHAIN_BITS-1 into the chain head
//   ST_VERIFY | setup=1, image shifted again, tail compared bit by bit
//   ST_DONE   | one-cycle done pulse with ok
module bnn_param_loader #(
   parameter  int NEURONS               = bnn_pkg::NEURONS,
   parameter  int PARAM_BITS_PER_NEURON = bnn_pkg::PARAM_BITS_PER_NEURON,
   localparam int CHAIN_BITS            = NEURONS * PARAM_BITS_PER_NEURON,
   localparam int CHAIN_BYTES           = CHAIN_BITS / 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   bnn_param_loader_if.slave   bus,
   output logic                busy,
   output logic                done,
   output logic                ok,
   output logic [6:0]          err_count
);

   import bnn_pkg::*;

   localparam int BIT_W  = $clog2(CHAIN_BITS);
   localparam int BYTE_W = $clog2(CHAIN_BYTES);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_BITS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(CHAIN_BYTES - 1);
   localparam logic [6:0]        ERR_MAX   = 7'd127;

   loader_state_t     state;
   logic [BYTE_W-1:0] byte_idx;
   logic [BIT_W-1:0]  bit_idx;
   logic [BIT_W-1:0]  rd_idx;
   logic              in_ready_q;
   logic              setup_q;
   logic              param_out_q;
   logic              wr_en;
   logic              rd_bit;
   logic              last_bit;
   logic              mismatch;
   logic [6:0]        err_next;

   assign wr_en    = (state == ST_FILL) && bus.in_valid && in_ready_q;
   assign last_bit = (bit_idx == LAST_BIT);

   // param_out is registered, so the buffer is read one bit ahead of bit_idx.
   always_comb begin
      rd_idx = '0;
      if ((state == ST_SHIFT || state == ST_VERIFY) && !last_bit)
         rd_idx = bit_idx + BIT_W'(1);
   end

   // The chain delay equals CHAIN_BITS, so in VERIFY the tail lines up with
   // the bit currently driven on param_out.
   always_comb begin
      mismatch = (bus.param_return != param_out_q);
      err_next = err_count;
      if (mismatch && (err_count != ERR_MAX)) err_next = err_count + 7'd1;
   end

   bnn_param_buffer #(
      .CHAIN_BYTES (CHAIN_BYTES)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (byte_idx),
      .wr_data (bus.in_data),
      .rd_idx  (rd_idx),
      .rd_bit  (rd_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         byte_idx    <= '0;
         bit_idx     <= '0;
         in_ready_q  <= 1'b0;
         setup_q     <= 1'b0;
         param_out_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ok          <= 1'b0;
         err_count   <= '0;
      end else if (abort) begin
         state       <= ST_IDLE;
         in_ready_q  <= 1'b0;
         setup_q     <= 1'b0;
         param_out_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ok          <= 1'b0;
         err_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_FILL;
                  byte_idx   <= '0;
                  ok         <= 1'b0;
                  err_count  <= '0;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_FILL: begin
               if (wr_en) begin
                  if (byte_idx == LAST_BYTE) begin
                     state       <= ST_SHIFT;
                     in_ready_q  <= 1'b0;
                     setup_q     <= 1'b1;
                     param_out_q <= rd_bit;
                     bit_idx     <= '0;
                  end else begin
                     byte_idx <= byte_idx + BYTE_W'(1);
                  end
               end
            end
            ST_SHIFT: begin
               param_out_q <= rd_bit;
               if (last_bit) begin
                  state   <= ST_VERIFY;
                  bit_idx <= '0;
               end else begin
                  bit_idx <= bit_idx + BIT_W'(1);
               end
            end
            ST_VERIFY: begin
               err_count <= err_next;
               if (last_bit) begin
                  state       <= ST_DONE;
                  setup_q     <= 1'b0;
                  param_out_q <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  ok          <= (err_next == 7'd0);
               end else begin
                  param_out_q <= rd_bit;
                  bit_idx     <= bit_idx + BIT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.setup     = setup_q;
   assign bus.param_out = param_out_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader with a behavioural neuron-chain shift register.
module tb_bnn_param_loader;

   localparam int CB = 96;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic       ok;
   logic [6:0] err_count;

   bnn_param_loader_if bus ();

   bnn_param_loader #(
      .NEURONS               (8),
      .PARAM_BITS_PER_NEURON (12)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .ok        (ok),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pos_cyc = 0;
   int run = 0;
   int done_cnt = 0;
   int fault_mode = 0;
   logic [CB-1:0] chain = '0;
   logic [7:0] img [12];
   logic flip;

   always @(posedge clk) begin
      pos_cyc <= pos_cyc + 1;
      run     <= bus.setup ? run + 1 : 0;
      if (bus.setup) chain <= {chain[CB-2:0], bus.param_out};
   end

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   // run = CB + k during VERIFY cycle k
   assign flip = (fault_mode == 1) && (run == CB + 5 || run == CB + 40);
   assign bus.param_return = (fault_mode == 2) ? 1'b0 : (chain[CB-1] ^ flip);

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_load(input int mode, input bit stall, input int exp_err,
                           input int abort_at, input int rst_at, input string tag);
      int acc, idx, g, set_cnt, dc;
      logic [CB-1:0] got, expv;
      bit early;
      fault_mode = mode;
      for (int k = 0; k < CB; k++) expv[k] = img[k/8][7-(k%8)];
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, " in_ready_after_start"}, 32'(bus.in_ready), 1);
      idx = 0; g = 0; acc = 0; early = 1'b0;
      while (idx < 12 && g < 100) begin
         bus.in_valid = stall ? ((g % 2) == 0) : 1'b1;
         bus.in_data  = img[idx];
         if (bus.setup) early = 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            idx++;
            acc = pos_cyc;
         end
         g++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      chk({tag, " bytes_accepted"}, idx, 12);
      chk({tag, " setup_during_fill"}, 32'(early), 0);
      set_cnt = 0;
      for (int j = 0; j < CB; j++) begin
         if (j == abort_at) begin
            dc = done_cnt;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk({tag, " setup_after_abort"}, 32'(bus.setup), 0);
            chk({tag, " param_out_after_abort"}, 32'(bus.param_out), 0);
            chk({tag, " busy_after_abort"}, 32'(busy), 0);
            chk({tag, " err_count_after_abort"}, 32'(err_count), 0);
            repeat (250) @(negedge clk);
            #1;
            chk({tag, " no_done_after_abort"}, done_cnt, dc);
            return;
         end
         got[j] = bus.param_out;
         if (bus.setup) set_cnt++;
         @(negedge clk);
      end
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s shift_bits: observed %h expected %h", tag, got, expv);
      end
      g = 0;
      while (!done && g < 300) begin
         if (rst_at >= 0 && g == rst_at) begin
            #1 rst_n = 1'b0;
            #1;
            chk({tag, " rst_setup"}, 32'(bus.setup), 0);
            chk({tag, " rst_param_out"}, 32'(bus.param_out), 0);
            chk({tag, " rst_busy"}, 32'(busy), 0);
            chk({tag, " rst_err_count"}, 32'(err_count), 0);
            chk({tag, " rst_in_ready"}, 32'(bus.in_ready), 0);
            @(negedge clk); rst_n = 1'b1;
            @(negedge clk);
            chk({tag, " idle_after_release"}, 32'({busy, bus.setup, bus.in_ready, done}), 0);
            return;
         end
         if (bus.setup) set_cnt++;
         g++;
         @(negedge clk);
      end
      chk({tag, " done_seen"}, 32'(done), 1);
      chk({tag, " latency"}, pos_cyc - acc, 2 * CB + 1);
      chk({tag, " setup_cycles"}, set_cnt, 2 * CB);
      chk({tag, " ok"}, 32'(ok), (exp_err == 0) ? 1 : 0);
      chk({tag, " err_count"}, 32'(err_count), exp_err);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(done), 0);
      chk({tag, " busy_idle"}, 32'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset outputs", 32'({bus.setup, bus.param_out, bus.in_ready, busy, done, ok}), 0);
      chk("reset err_count", 32'(err_count), 0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h77;
      @(negedge clk);
      chk("idle in_ready", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b0;

      img = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h12, 8'h34, 8'hC3, 8'h99};
      run_load(0, 1'b0, 0, -1, -1, "clean");
      repeat (5) @(negedge clk);
      chk("ok held", 32'(ok), 1);

      run_load(1, 1'b0, 2, -1, -1, "flip");

      img = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_load(2, 1'b0, 96, -1, -1, "stuck0");

      img = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h12, 8'h34, 8'hC3, 8'h99};
      run_load(0, 1'b0, 0, 30, -1, "abort");
      run_load(0, 1'b1, 0, -1, -1, "stall");
      run_load(1, 1'b0, 2, -1, 50, "reset");
      run_load(0, 1'b0, 0, -1, -1, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Serial parameter loader for the binarized neuron array. It collects a full parameter image as a byte stream, then drives the neuron chain's `setup`/`param_in` shift interface for exactly one chain length. It then shifts the same image a second time while comparing the chain's `param_out` tail against the image, verifying the load by readback. It sits between the host-side byte source and the neuron chain, replacing hand-driven setup pins.

## Interface
Parameters:
- `NEURONS`, 8: neurons in the chain.
- `PARAM_BITS_PER_NEURON`, 12: shift-register bits per neuron.
- `CHAIN_BITS`, `NEURONS*PARAM_BITS_PER_NEURON` (96): total chain length; must be a multiple of 8.
- `CHAIN_BYTES`, `CHAIN_BITS/8` (12): bytes per image.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: single clock; the neuron chain runs on the same clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin a load; sampled only in IDLE.
- `abort` input 1: return to IDLE from any state.
- `in_data` input 8: image byte; the first byte holds chain bits 0..7, MSB first.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `setup` output 1: drives the neuron-chain setup.
- `param_out` output 1: serial bit into the chain head.
- `param_return` input 1: chain tail (last neuron's `param_out`).
- `busy` output 1: high in FILL, SHIFT and VERIFY.
- `done` output 1: one-cycle pulse at end of VERIFY.
- `ok` output 1: verify result; valid from `done`, held until next `start`.
- `err_count` output 7: mismatching bits in the last verify, saturating at 127.

## Operation
- States: IDLE, FILL, SHIFT, VERIFY, DONE.
- IDLE:
  - `start`=1 → FILL.
  - Entering FILL clears byte index, `ok`, and `err_count`.
- FILL:
  - `in_ready`=1, `setup`=0.
  - Each cycle with `in_valid&&in_ready` writes `in_data` to byte slot `idx`, then `idx++`.
  - After byte `CHAIN_BYTES-1` is accepted → SHIFT, with bit counter k=0.
- SHIFT:
  - `setup`=1, `param_out`=image bit k (k=0..CHAIN_BITS-1), one bit per cycle with no stalls.
  - At k=CHAIN_BITS-1 → VERIFY, k=0.
- VERIFY:
  - `setup`=1, `param_out`=image bit k again, so chain contents end up unchanged.
  - Each cycle, compare `param_return` with image bit k. On mismatch, `err_count` increments (saturating).
  - At k=CHAIN_BITS-1 → DONE.
- DONE:
  - One cycle: `done`=1, `ok`=(`err_count`==0), `setup`=0.
  - Then → IDLE.
- `abort` (any state): next cycle IDLE; `setup`=0, `in_ready`=0, `param_out`=0. `ok` and `err_count` are cleared and `done` is not pulsed.
- `start` outside IDLE is ignored. If `start` and `abort` are asserted together, `abort` wins.
- Bytes presented outside FILL are not accepted (`in_ready`=0).
- The image buffer is not cleared by reset or abort; FILL always overwrites all bytes.

## Timing
- All outputs are registered.
- Reset values: `setup`=0, `param_out`=0, `in_ready`=0, `busy`=0, `done`=0, `ok`=0, `err_count`=0; state IDLE.
- `start` seen at edge N:
  - `in_ready`=1 from cycle N+1.
  - With back-to-back bytes, the last byte is accepted at cycle N+CHAIN_BYTES.
- SHIFT occupies exactly CHAIN_BITS cycles with `setup`=1, immediately followed by VERIFY for CHAIN_BITS cycles.
- `setup` is continuously high for 2·CHAIN_BITS cycles (192 at defaults).
- Verify alignment:
  - The chain delay is exactly CHAIN_BITS cycles.
  - `param_return` in VERIFY cycle k must equal the bit driven in SHIFT cycle k.
- Total latency from the last byte accepted to `done`: 2·CHAIN_BITS+1 cycles.
- Reset asserted mid-operation forces all outputs to reset values immediately (asynchronous).

## Structure
- Shared package `bnn_pkg`: state enum `loader_state_t`, plus `NEURONS` and `PARAM_BITS_PER_NEURON` defaults shared with the neuron array.
- One sub-module is natural: `bnn_param_buffer`, CHAIN_BYTES×8 storage with a byte write port and a bit read port indexed by k (MSB-first within each byte).
- Counters and FSM live in the top.

## Test plan
- Reset mid-VERIFY (`rst_n`=0) → all outputs go to reset values in the same cycle; state IDLE after release.
- Load image 0xA5,0x3C,… (12 bytes) into a 96-bit behavioral shift-register model:
  - `param_out` during SHIFT reproduces bits MSB-first.
  - `done` arrives 193 cycles after the last byte, with `ok`=1 and `err_count`=0.
- Same load with the model flipping `param_return` at VERIFY cycles 5 and 40 → `ok`=0, `err_count`=2.
- Stuck-at-0 tail with image all 0xFF → `err_count`=96.
- Stalled input: `in_valid` toggling 1/0 → `setup` stays 0 until all 12 bytes are accepted; the SHIFT sequence is unchanged.
- `abort` at SHIFT cycle 30 → `setup`=0 the next cycle, no `done`; a subsequent `start` runs a full clean load.
